ad_cali_multi: RTL and testbench

//  Multi-channel AD7606 sample calibrator, successor to the single-channel calibrator.

---
 rtl/ad_cali_multi.sv | 187 ++++++++++++++++++
 tb/tb_ad_cali_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_cali_multi.sv
// Multi-channel AD7606 sample calibrator.
// Averages 2^avg_log2 frames per channel, then streams one result per channel
// computed as sat(((avg - ofs) * gain) >>> 30) through a 3-stage pipeline.
module ad_cali_multi #(
  parameter int CH_NUM  = 8,
  parameter int DATA_W  = 16,
  parameter int GAIN_W  = 32,
  parameter int OUT_W   = 32,
  parameter int MAX_AVG = 4,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cali_en,
  input  logic [2:0]               avg_log2,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_wr,
  input  logic [CH_W-1:0]          coef_ch,
  input  logic signed [GAIN_W-1:0] coef_gain,
  input  logic signed [DATA_W-1:0] coef_ofs,
  output logic                     busy,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  result,
  output logic                     done
);

  localparam int ACC_W  = DATA_W + MAX_AVG;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DIFF_W + GAIN_W;
  localparam int SAT_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);
  localparam logic signed [GAIN_W-1:0] GAIN_ONE = GAIN_W'(64'sd1 << 30);

  typedef enum logic [2:0] {IDLE, ARM, ACC, CALC, DRAIN} state_t;

  state_t state, state_nxt;

  logic [2:0]                avg_sh;
  logic [MAX_AVG:0]          frame_cnt;
  logic [MAX_AVG:0]          frame_tgt;
  logic [CH_W-1:0]           issue_ch;
  logic signed [ACC_W-1:0]   acc  [CH_NUM];
  logic signed [GAIN_W-1:0]  gain [CH_NUM];
  logic signed [DATA_W-1:0]  ofs  [CH_NUM];

  logic start, take, frame_end, frames_done, issue, in_ok, coef_ok;

  logic signed [DATA_W-1:0]  avg_p0;
  logic signed [DIFF_W-1:0]  diff_p0;
  logic                      vld_p1, vld_p2;
  logic [CH_W-1:0]           ch_p1, ch_p2;
  logic signed [DIFF_W-1:0]  diff_p1;
  logic signed [GAIN_W-1:0]  gain_p1;
  logic signed [PROD_W-1:0]  prod_p2;

  // Floor-shift a Q2.30 product down to integer and clamp into the output range.
  function automatic logic signed [OUT_W-1:0] sat_q30(input logic signed [PROD_W-1:0] p);
    logic signed [SAT_W-1:0] s, hi, lo;
    s  = SAT_W'(p >>> 30);
    hi = SAT_W'({1'b0, {(OUT_W-1){1'b1}}});
    lo = ~hi;
    if (s > hi)      return hi[OUT_W-1:0];
    else if (s < lo) return lo[OUT_W-1:0];
    else             return s[OUT_W-1:0];
  endfunction

  assign in_ok       = ({1'b0, in_ch} < (CH_W+1)'(CH_NUM));
  assign coef_ok     = ({1'b0, coef_ch} < (CH_W+1)'(CH_NUM));
  assign start       = (state == IDLE) && cali_en;
  assign take        = in_valid && in_ok &&
                       ((state == ACC) || ((state == ARM) && (in_ch == '0)));
  assign frame_end   = take && (in_ch == CH_LAST);
  assign frame_tgt   = (MAX_AVG+1)'(1) << avg_sh;
  assign frames_done = frame_end && ((frame_cnt + 1'b1) == frame_tgt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: arm, align to channel 0, accumulate, issue, drain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cali_en) state_nxt = ARM;
      ARM:     if (take) state_nxt = frames_done ? CALC : ACC;
      ACC:     if (frames_done) state_nxt = CALC;
      CALC:    if (issue_ch == CH_LAST) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy  = (state != IDLE);
    issue = (state == CALC);
  end

  // Run control: averaging depth, frame counter and issue channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_sh    <= '0;
      frame_cnt <= '0;
      issue_ch  <= '0;
    end else begin
      if (start) begin
        avg_sh    <= (avg_log2 > 3'(MAX_AVG)) ? 3'(MAX_AVG) : avg_log2;
        frame_cnt <= '0;
        issue_ch  <= '0;
      end else begin
        if (frame_end) frame_cnt <= frame_cnt + 1'b1;
        if (issue)     issue_ch  <= (issue_ch == CH_LAST) ? '0 : issue_ch + 1'b1;
      end
    end
  end

  // Per-channel accumulators, cleared at reset and at every accepted start.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < CH_NUM; i++) acc[i] <= '0;
    end else if (take) begin
      acc[in_ch] <= acc[in_ch] + ACC_W'(in_data);
    end
  end

  // Coefficient table; writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        gain[i] <= GAIN_ONE;
        ofs[i]  <= '0;
      end
    end else if (coef_wr && !busy && coef_ok) begin
      gain[coef_ch] <= coef_gain;
      ofs[coef_ch]  <= coef_ofs;
    end
  end

  assign avg_p0  = DATA_W'(acc[issue_ch] >>> avg_sh);
  assign diff_p0 = DIFF_W'(avg_p0) - DIFF_W'(ofs[issue_ch]);

  // ---- stage 1: average and offset removal ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    ch_p1   <= issue_ch;
    diff_p1 <= diff_p0;
    gain_p1 <= gain[issue_ch];
  end

  // ---- stage 2: gain multiply ----
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    ch_p2   <= ch_p1;
    prod_p2 <= PROD_W'(diff_p1) * PROD_W'(gain_p1);
  end

  // ---- stage 3: scale, saturate and register outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_ch    <= '0;
      result    <= '0;
    end else begin
      out_valid <= vld_p2;
      done      <= vld_p2 && (ch_p2 == CH_LAST);
      if (vld_p2) begin
        out_ch <= ch_p2;
        result <= sat_q30(prod_p2);
      end
    end
  end

endmodule

// File: tb/tb_ad_cali_multi.sv
// Testbench for ad_cali_multi: directed scenarios plus randomized runs,
// checked against an arithmetic reference model on two instances (OUT_W 32 and 16).
module tb_ad_cali_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               cali_en = 1'b0;
  logic [2:0]         avg_log2 = '0;
  logic               in_valid = 1'b0;
  logic [2:0]         in_ch = '0;
  logic signed [15:0] in_data = '0;
  logic               coef_wr = 1'b0;
  logic [2:0]         coef_ch = '0;
  logic signed [31:0] coef_gain = '0;
  logic signed [15:0] coef_ofs = '0;

  logic               busy_a, out_valid_a, done_a;
  logic [2:0]         out_ch_a;
  logic signed [31:0] result_a;
  logic               busy_b, out_valid_b, done_b;
  logic [2:0]         out_ch_b;
  logic signed [15:0] result_b;

  ad_cali_multi #(.OUT_W(32)) dut_a (
    .clk(clk), .rst(rst), .cali_en(cali_en), .avg_log2(avg_log2),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .coef_wr(coef_wr), .coef_ch(coef_ch), .coef_gain(coef_gain), .coef_ofs(coef_ofs),
    .busy(busy_a), .out_valid(out_valid_a), .out_ch(out_ch_a), .result(result_a), .done(done_a)
  );

  ad_cali_multi #(.OUT_W(16)) dut_b (
    .clk(clk), .rst(rst), .cali_en(cali_en), .avg_log2(avg_log2),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .coef_wr(coef_wr), .coef_ch(coef_ch), .coef_gain(coef_gain), .coef_ofs(coef_ofs),
    .busy(busy_b), .out_valid(out_valid_b), .out_ch(out_ch_b), .result(result_b), .done(done_b)
  );

  // Reference model state: coefficients, per-run channel sums, averaging depth.
  longint m_gain [8];
  longint m_ofs  [8];
  longint m_sum  [8];
  int     m_k;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Expected result: floor average, minus offset, times gain/2^30 floored, clamped to w bits.
  function automatic longint expect_res(input int ch, input int w);
    longint avg, v, hi, lo;
    avg = fdiv(m_sum[ch], longint'(1) << m_k);
    v   = fdiv((avg - m_ofs[ch]) * m_gain[ch], longint'(1) << 30);
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  function automatic longint rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return longint'(v);
  endfunction

  function automatic longint rnd32();
    int v;
    v = int'($urandom);
    return longint'(v);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_defaults();
    for (int i = 0; i < 8; i++) begin
      m_gain[i] = 64'sd1073741824;
      m_ofs[i]  = 0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_defaults();
  endtask

  task automatic write_coef(input int ch, input longint g, input longint o);
    coef_wr = 1'b1; coef_ch = 3'(ch); coef_gain = 32'(g); coef_ofs = 16'(o);
    tick();
    coef_wr = 1'b0;
    m_gain[ch] = g;
    m_ofs[ch]  = o;
  endtask

  task automatic start_run(input int k);
    cali_en = 1'b1; avg_log2 = 3'(k);
    tick();
    cali_en = 1'b0; coef_wr = 1'b0;
    m_k = (k > 4) ? 4 : k;
    for (int i = 0; i < 8; i++) m_sum[i] = 0;
    chk("busy_after_start", busy_a, 1);
  endtask

  task automatic send(input int ch, input longint d, input bit counted);
    in_valid = 1'b1; in_ch = 3'(ch); in_data = 16'(d);
    tick();
    in_valid = 1'b0;
    if (counted) m_sum[ch] += d;
  endtask

  task automatic send_frame(input longint d [8], input logic [7:0] mask);
    for (int c = 0; c < 8; c++) if (mask[c]) send(c, d[c], 1'b1);
  endtask

  task automatic rand_frame(input logic [7:0] mask);
    longint d [8];
    for (int c = 0; c < 8; c++) d[c] = rnd16();
    send_frame(d, mask);
  endtask

  // Collect results; with abort set, reset is raised right after result n-1.
  task automatic collect(input string tag, input int n, input bit abort);
    int t;
    t = 0;
    while (!out_valid_a && t < 40) begin tick(); t++; end
    if (!out_valid_a) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk({tag, "_vld_a"}, out_valid_a, 1);
      chk({tag, "_ch_a"}, out_ch_a, i);
      chk({tag, "_res_a"}, result_a, expect_res(i, 32));
      chk({tag, "_done_a"}, done_a, (i == 7));
      chk({tag, "_vld_b"}, out_valid_b, 1);
      chk({tag, "_res_b"}, result_b, expect_res(i, 16));
      chk({tag, "_done_b"}, done_b, (i == 7));
      if (abort && i == n - 1) rst = 1'b1;
      tick();
    end
    if (!abort) begin
      chk({tag, "_busy_end"}, busy_a, 0);
      chk({tag, "_vld_end"}, out_valid_a, 0);
      chk({tag, "_done_end"}, done_a, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d [8];
    bit seen;

    // 1: reset values and unity calibration
    reset_dut();
    chk("rst_busy", busy_a, 0);
    chk("rst_vld", out_valid_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ch", out_ch_a, 0);
    chk("rst_res", result_a, 0);
    chk("rst_res_b", result_b, 0);
    start_run(0);
    for (int c = 0; c < 8; c++) d[c] = c + 1;
    send_frame(d, 8'hFF);
    collect("t1", 8, 1'b0);
    chk("t1_res0_const", result_a, 8);

    // 2: coefficient write together with start; floor on negative
    coef_wr = 1'b1; coef_ch = 3'd0; coef_gain = 32'sh20000000; coef_ofs = 16'sd100;
    m_gain[0] = 64'sh20000000; m_ofs[0] = 100;
    start_run(0);
    for (int c = 0; c < 8; c++) d[c] = rnd16();
    d[0] = 300;
    send_frame(d, 8'hFF);
    collect("t2a", 8, 1'b0);
    start_run(0);
    d[0] = 99;
    send_frame(d, 8'hFF);
    collect("t2b", 8, 1'b0);

    // 3: four-frame average
    reset_dut();
    start_run(2);
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 8; c++) d[c] = rnd16();
      d[0] = f + 1;
      d[1] = -8;
      send_frame(d, 8'hFF);
    end
    collect("t3", 8, 1'b0);

    // 4: saturation at both ends
    write_coef(0, 64'sh7FFFFFFF, -32768);
    start_run(0);
    d[0] = 32767;
    send_frame(d, 8'hFF);
    collect("t4a", 8, 1'b0);
    write_coef(0, 64'sh7FFFFFFF, 32767);
    start_run(0);
    d[0] = -32768;
    send_frame(d, 8'hFF);
    collect("t4b", 8, 1'b0);

    // randomized runs: random coefficients, depth (incl. clamped), a partial frame
    for (int r = 0; r < 4; r++) begin
      int k, nf;
      for (int c = 0; c < 8; c++) write_coef(c, rnd32(), rnd16());
      k = (r == 3) ? 7 : int'($urandom_range(0, 7));
      start_run(k);
      nf = 1 << m_k;
      for (int f = 0; f < nf; f++) rand_frame((f == 0 && nf > 1) ? 8'hFB : 8'hFF);
      collect("rnd", 8, 1'b0);
    end

    // 5: start and coefficient write ignored while busy; pre-align samples dropped
    start_run(1);
    send(3, rnd16(), 1'b0);
    send(5, rnd16(), 1'b0);
    rand_frame(8'hFF);
    cali_en = 1'b1; coef_wr = 1'b1; coef_ch = 3'd0; coef_gain = '0; coef_ofs = 16'sd5;
    tick();
    cali_en = 1'b0; coef_wr = 1'b0;
    chk("t5_busy_mid", busy_a, 1);
    rand_frame(8'hFF);
    collect("t5", 8, 1'b0);

    // 6: reset mid-CALC aborts the run, then defaults give unity
    start_run(0);
    rand_frame(8'hFF);
    collect("t6", 2, 1'b1);
    tick();
    rst = 1'b0;
    model_defaults();
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (out_valid_a || done_a || out_valid_b || done_b) seen = 1'b1;
      tick();
    end
    chk("t6_no_out", seen, 0);
    chk("t6_busy", busy_a, 0);
    start_run(0);
    rand_frame(8'hFF);
    collect("t6_unity", 8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
